line_sensor_decoder: RTL

- Downstream consumer of the ADC128S022 front-end, clocked on the same 50 MHz clock.
- Takes the three parallel 12-bit line-sensor readings and the 2-bit data_frame sweep indicator.
- Once per 3-channel sweep it thresholds each sensor with hysteresis and debounces the 3-bit pattern across sweeps.
- A small follow/node/lost state machine turns the pattern into a steering direction code and a node counter for the motor controller.

---
 rtl/line_pkg.sv | 13 +
 rtl/line_sensor_decoder_if.sv | 19 +
 rtl/hyst_threshold.sv | 19 +
 rtl/line_sensor_decoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// line_pkg: shared direction codes, FSM states, pattern constants and pattern decode
package line_pkg;
  typedef enum logic [2:0] {DIR_STOP, DIR_FWD, DIR_LEFT, DIR_RIGHT, DIR_SEARCH} dir_t;
  typedef enum logic [1:0] {ST_FOLLOW, ST_NODE, ST_LOST, ST_HALT} state_t;
  localparam logic [2:0] PAT_NODE = 3'b111;
  localparam logic [2:0] PAT_NONE = 3'b000;
  // 101 (and the node/none patterns, handled by the FSM) keep the previous steering
  function automatic dir_t decode(input logic [2:0] p, input dir_t prev);
    return (p == 3'b010) ? DIR_FWD :
           (p == 3'b110 || p == 3'b100) ? DIR_LEFT :
           (p == 3'b011 || p == 3'b001) ? DIR_RIGHT : prev;
  endfunction
endpackage

// File: rtl/line_sensor_decoder_if.sv
// line_sensor_decoder_if: sensor readings + sweep indicator in, pattern/steering/node status out
// master drives ch_left/ch_center/ch_right/data_frame; slave drives line_pattern, pattern_valid,
// dir, node_pulse, node_count, fsm_state
interface line_sensor_decoder_if;
  logic [11:0] ch_left;
  logic [11:0] ch_center;
  logic [11:0] ch_right;
  logic [1:0]  data_frame;
  logic [2:0]  line_pattern;
  logic        pattern_valid;
  logic [2:0]  dir;
  logic        node_pulse;
  logic [7:0]  node_count;
  logic [1:0]  fsm_state;
  modport master(output ch_left, ch_center, ch_right, data_frame,
                 input line_pattern, pattern_valid, dir, node_pulse, node_count, fsm_state);
  modport slave(input ch_left, ch_center, ch_right, data_frame,
                output line_pattern, pattern_valid, dir, node_pulse, node_count, fsm_state);
endinterface

// File: rtl/hyst_threshold.sv
// hyst_threshold: one channel's hysteresis comparator with its line-bit register
// ports: clk_50, rst_n (sync active-low), i_en (sweep tick), i_val (12-bit reading), o_bit (line bit)
module hyst_threshold #(
  parameter logic [11:0] TH_HI = 12'd2000,
  parameter logic [11:0] TH_LO = 12'd1600
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [11:0] i_val,
  output logic        o_bit
);
  logic r_bit;
  always_ff @(posedge clk_50) begin
    if (!rst_n) r_bit <= 1'b0;
    else if (i_en) r_bit <= r_bit ? (i_val >= TH_LO) : (i_val >= TH_HI);
  end
  assign o_bit = r_bit;
endmodule

// File: rtl/line_sensor_decoder.sv
// line_sensor_decoder: per-sweep hysteresis threshold, debounce and follow/node/lost steering FSM
// ports: clk_50, rst_n (sync active-low), bus (line_sensor_decoder_if.slave: readings and
// data_frame in; line_pattern, pattern_valid, dir, node_pulse, node_count, fsm_state out)
module line_sensor_decoder
  import line_pkg::*;
#(
  parameter logic [11:0] TH_HI = 12'd2000,
  parameter logic [11:0] TH_LO = 12'd1600,
  parameter int DEBOUNCE = 2,
  parameter int LOST_TIMEOUT = 64
) (
  input  logic clk_50,
  input  logic rst_n,
  line_sensor_decoder_if.slave bus
);
  logic [1:0] r_frame_q;
  logic       r_tick_d;
  logic [2:0] r_cand;
  logic [3:0] r_cnt;
  logic [2:0] r_pat;
  logic       r_valid;
  logic       r_commit;
  state_t     r_state;
  dir_t       r_dir;
  logic       r_pulse;
  logic [7:0] r_nodes;
  logic [7:0] r_lost;
  logic       w_tick;
  logic [2:0] w_raw;
  logic [3:0] w_cnt_nxt;
  logic       w_commit;
  assign w_tick = (bus.data_frame != r_frame_q) && (bus.data_frame == 2'd1);
  hyst_threshold #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_left (
    .clk_50(clk_50), .rst_n(rst_n), .i_en(w_tick), .i_val(bus.ch_left), .o_bit(w_raw[2]));
  hyst_threshold #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_center (
    .clk_50(clk_50), .rst_n(rst_n), .i_en(w_tick), .i_val(bus.ch_center), .o_bit(w_raw[1]));
  hyst_threshold #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_right (
    .clk_50(clk_50), .rst_n(rst_n), .i_en(w_tick), .i_val(bus.ch_right), .o_bit(w_raw[0]));
  // the count stays saturated while the pattern is stable, so every stable sweep re-commits
  always_comb begin
    w_cnt_nxt = (w_raw != r_cand) ? 4'd1 : (r_cnt == 4'(DEBOUNCE)) ? r_cnt : r_cnt + 4'd1;
    w_commit = r_tick_d && (w_cnt_nxt == 4'(DEBOUNCE));
  end
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_frame_q <= 2'd0;
      r_tick_d <= 1'b0;
      r_cand <= 3'd0;
      r_cnt <= 4'd0;
      r_pat <= 3'd0;
      r_valid <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_frame_q <= bus.data_frame;
      r_tick_d <= w_tick;
      r_commit <= w_commit;
      if (r_tick_d) begin
        r_cand <= w_raw;
        r_cnt <= w_cnt_nxt;
      end
      if (w_commit) begin
        r_pat <= w_raw;
        r_valid <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      r_state <= ST_FOLLOW;
      r_dir <= DIR_STOP;
      r_pulse <= 1'b0;
      r_nodes <= 8'd0;
      r_lost <= 8'd0;
    end else begin
      r_pulse <= 1'b0;
      if (r_commit && r_valid) begin
        if (r_state == ST_HALT) begin
          r_dir <= DIR_STOP;
        end else if (r_state == ST_LOST && r_pat == PAT_NONE) begin
          if (r_lost == 8'(LOST_TIMEOUT - 1)) begin
            r_state <= ST_HALT;
            r_dir <= DIR_STOP;
          end else begin
            r_lost <= r_lost + 8'd1;
          end
        end else if (r_state == ST_NODE && r_pat == PAT_NODE) begin
          r_dir <= DIR_FWD;
        end else if (r_pat == PAT_NODE) begin
          r_state <= ST_NODE;
          r_dir <= DIR_FWD;
          r_pulse <= 1'b1;
          r_nodes <= (r_nodes == 8'hFF) ? r_nodes : r_nodes + 8'd1;
        end else if (r_pat == PAT_NONE) begin
          r_state <= ST_LOST;
          r_lost <= 8'd0;
          r_dir <= DIR_SEARCH;
        end else begin
          r_state <= ST_FOLLOW;
          r_dir <= decode(r_pat, r_dir);
        end
      end
    end
  end
  assign bus.line_pattern = r_pat;
  assign bus.pattern_valid = r_valid;
  assign bus.dir = r_dir;
  assign bus.node_pulse = r_pulse;
  assign bus.node_count = r_nodes;
  assign bus.fsm_state = r_state;
endmodule
